// File: rtl/membus_pkg.sv
// Shared decode definitions for the membus target: region encoding,
// peripheral offsets and the RAM/ROM bounds of the 20-bit core address space.
package membus_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_ROM,
    REG_PERIPH
  } region_t;

  localparam logic [3:0] OFF_STATUS = 4'd0;
  localparam logic [3:0] OFF_DATA   = 4'd1;
  localparam logic [3:0] OFF_TICKS0 = 4'd2;
  localparam logic [3:0] OFF_TICKS1 = 4'd3;
  localparam logic [3:0] OFF_TICKS2 = 4'd4;
  localparam logic [3:0] OFF_TICKS3 = 4'd5;

  localparam logic [19:0] RAM_TOP  = 20'hEFFFF;
  localparam logic [19:0] ROM_BASE = 20'hF0000;

  // The peripheral window takes priority over whatever region it overlays.
  function automatic region_t decode_region(input logic [19:0] addr,
                                            input logic [19:0] periph_base);
    if (addr[19:4] == periph_base[19:4]) return REG_PERIPH;
    else if (addr < ROM_BASE && addr <= RAM_TOP) return REG_RAM;
    else return REG_ROM;
  endfunction

endpackage

// File: rtl/membus_target_fifo.sv
// Keyboard scancode FIFO: power-of-2 circular buffer with wrapping pointers,
// occupancy count and a sticky overflow flag.
module scancode_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push)  overflow <= 1'b1;
      else if (clr_ovf)      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/membus_target.sv
// Byte-wide bus target: RAM/ROM/peripheral decode with 1-cycle read latency.
// Define MEMBUS_KBD_FIFO_EN to build the scancode FIFO and STATUS/DATA registers.
module membus_target
  import membus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [19:0] PERIPH_BASE = 20'hE0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] address,
  input  logic [7:0]  wdata,
  input  logic        wren,
  output logic [7:0]  rdata,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid
);

  region_t     region;
  region_t     region_q;
  logic [3:0]  offset;
  logic [19:0] prev_addr;
  logic        prev_wren;
  logic        first;
  logic        periph_rd;
  logic        periph_wr;
  logic [31:0] ticks;
  logic [31:0] snap;
  logic [7:0]  periph_q;
  logic [7:0]  status_byte;
  logic [7:0]  data_byte;

  assign region    = decode_region(address, PERIPH_BASE);
  assign offset    = address[3:0];
  assign first     = (address != prev_addr) || prev_wren;
  assign periph_rd = (region == REG_PERIPH) && !wren;
  assign periph_wr = (region == REG_PERIPH) && wren;

  assign mem_addr  = address;
  assign mem_wdata = wdata;
  assign mem_we    = wren && reset_n && (region == REG_RAM);

`ifdef MEMBUS_KBD_FIFO_EN
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic [4:0]    count_ext;
  logic [3:0]    count_disp;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_ovf;
  logic          pop;
  logic          clr_ovf;
  logic          unused_fifo;

  assign pop     = periph_rd && first && (offset == OFF_DATA);
  assign clr_ovf = periph_wr && (offset == OFF_STATUS);

  scancode_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (kbd_valid),
    .din      (kbd_data),
    .pop      (pop),
    .clr_ovf  (clr_ovf),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_ovf)
  );

  // A 16-deep FIFO holds one more entry than the 4-bit count field shows.
  assign count_ext   = 5'(fifo_count);
  assign count_disp  = count_ext[4] ? 4'hF : count_ext[3:0];
  assign status_byte = {count_disp, 2'b00, fifo_ovf, !fifo_empty};
  assign data_byte   = fifo_empty ? 8'h00 : fifo_head;
  assign unused_fifo = fifo_full;
`else
  logic unused_kbd;

  assign status_byte = '0;
  assign data_byte   = '0;
  assign unused_kbd  = ^{kbd_data, kbd_valid, 5'(FIFO_DEPTH)};
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_addr <= '0;
      prev_wren <= 1'b0;
      region_q  <= REG_PERIPH;
      periph_q  <= '0;
      ticks     <= '0;
      snap      <= '0;
    end else begin
      prev_addr <= address;
      prev_wren <= wren;
      region_q  <= region;
      ticks     <= ticks + 32'd1;
      if (region == REG_PERIPH) begin
        if (wren) begin
          periph_q <= '0;
        end else begin
          // Held DATA/TICKS0 accesses keep the byte from their first cycle.
          case (offset)
            OFF_STATUS: periph_q <= status_byte;
            OFF_DATA:   if (first) periph_q <= data_byte;
            OFF_TICKS0: begin
              if (first) begin
                snap     <= ticks;
                periph_q <= ticks[7:0];
              end else begin
                periph_q <= snap[7:0];
              end
            end
            OFF_TICKS1: periph_q <= snap[15:8];
            OFF_TICKS2: periph_q <= snap[23:16];
            OFF_TICKS3: periph_q <= snap[31:24];
            default:    periph_q <= '0;
          endcase
        end
      end
    end
  end

  // region_q resets to PERIPH with periph_q clear so rdata reads 00h out of reset.
  assign rdata = (region_q == REG_PERIPH) ? periph_q : mem_q;

endmodule

// File: tb/tb_membus_target.sv
// Self-checking bench for membus_target: directed test-plan cases plus random
// bus traffic checked against a queue-based reference model.
module tb_membus_target;

`ifdef MEMBUS_KBD_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int          DEPTH = 8;
  localparam logic [19:0] PB    = 20'hE0000;
  localparam logic [19:0] IDLE  = 20'h00100;
  localparam logic [19:0] ST    = PB + 20'd0;
  localparam logic [19:0] DT    = PB + 20'd1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] address = '0;
  logic [7:0]  wdata = '0;
  logic        wren = 1'b0;
  logic [7:0]  rdata;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_q = '0;
  logic [7:0]  kbd_data = '0;
  logic        kbd_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  membus_target #(.FIFO_DEPTH(DEPTH), .PERIPH_BASE(PB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .address   (address),
    .wdata     (wdata),
    .wren      (wren),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_q     (mem_q),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid)
  );

  always #5 clock = ~clock;

  // External memory: synchronous read, written only when mem_we is asserted.
  logic [7:0] env_mem [logic [19:0]];
  always @(posedge clock) begin
    mem_q <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : 8'h00;
    if (mem_we) env_mem[mem_addr] = mem_wdata;
  end

  // Reference: cycles elapsed since reset release.
  logic [31:0] mt = '0;
  always @(posedge clock) begin
    if (!reset_n) mt <= '0;
    else          mt <= mt + 32'd1;
  end

  logic [7:0]  model_mem [logic [19:0]];
  logic [7:0]  q [$];
  logic        m_ovf;
  logic [31:0] m_snap;
  logic [19:0] m_prev_a;
  logic        m_prev_w;
  logic [7:0]  last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [19:0] a, input logic w, input logic [7:0] d,
                            input logic kv, input logic [7:0] kd,
                            output logic [7:0] exp, output logic chk, output logic exp_we);
    logic first;
    logic [3:0] off;
    int n;
    first  = (a != m_prev_a) || m_prev_w;
    off    = a[3:0];
    exp    = 8'h00;
    chk    = !w;
    exp_we = 1'b0;
    if ((a & 20'hFFFF0) == PB) begin
      if (!w) begin
        case (off)
          4'd0: if (FIFO_EN) begin
            n   = (q.size() > 15) ? 15 : q.size();
            exp = {n[3:0], 2'b00, m_ovf, q.size() != 0};
          end
          4'd1: if (FIFO_EN) begin
            if (first) exp = (q.size() != 0) ? q.pop_front() : 8'h00;
            else       chk = 1'b0;
          end
          4'd2: begin
            if (first) m_snap = mt;
            exp = m_snap[7:0];
          end
          4'd3: exp = m_snap[15:8];
          4'd4: exp = m_snap[23:16];
          4'd5: exp = m_snap[31:24];
          default: exp = 8'h00;
        endcase
      end else if (off == 4'd0 && FIFO_EN) begin
        m_ovf = 1'b0;
      end
    end else begin
      exp = model_mem.exists(a) ? model_mem[a] : 8'h00;
      if (a < 20'hF0000 && w) begin
        exp_we = 1'b1;
        model_mem[a] = d;
      end
    end
    if (FIFO_EN && kv) begin
      if (q.size() < DEPTH) q.push_back(kd);
      else m_ovf = 1'b1;
    end
    m_prev_a = a;
    m_prev_w = w;
  endtask

  // One bus cycle: drive, check combinational outputs, then the registered read.
  task automatic cyc(input logic [19:0] a, input logic w, input logic [7:0] d,
                     input logic kv, input logic [7:0] kd);
    logic [7:0] exp;
    logic chk;
    logic exp_we;
    address = a; wren = w; wdata = d; kbd_valid = kv; kbd_data = kd;
    model_step(a, w, d, kv, kd, exp, chk, exp_we);
    #1;
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, a);
    @(posedge clock); #1;
    last_rd = rdata;
    if (chk) check("rdata", rdata, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; address = 20'h01234; wren = 1'b1; wdata = 8'hEE; kbd_valid = 1'b0;
    #1;
    check("reset_mem_we", mem_we, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_rdata", rdata, 8'h00);
    q.delete();
    m_ovf = 1'b0; m_snap = '0; m_prev_a = '0; m_prev_w = 1'b0;
    reset_n = 1'b1; wren = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t0;
    logic [31:0] tv;
    logic [19:0] ra;
    int r;

    env_mem[20'hF0010] = 8'hA5; model_mem[20'hF0010] = 8'hA5;
    env_mem[20'hFFFFF] = 8'h3C; model_mem[20'hFFFFF] = 8'h3C;
    env_mem[20'hF0000] = 8'h77; model_mem[20'hF0000] = 8'h77;

    do_reset();

    cyc(20'h01234, 1'b1, 8'h5A, 1'b0, 8'h00);
    cyc(20'h01234, 1'b0, 8'h00, 1'b0, 8'h00);
    check("ram_roundtrip", last_rd, 8'h5A);
    cyc(20'hF0010, 1'b1, 8'hFF, 1'b0, 8'h00);
    cyc(20'hF0010, 1'b0, 8'h00, 1'b0, 8'h00);
    check("rom_protect", last_rd, 8'hA5);
    cyc(20'hE0010, 1'b1, 8'h11, 1'b0, 8'h00);
    cyc(20'hEFFFF, 1'b1, 8'h22, 1'b0, 8'h00);
    cyc(20'hE0010, 1'b0, 8'h00, 1'b0, 8'h00);
    check("ram_above_window", last_rd, 8'h11);
    cyc(PB + 20'd9, 1'b0, 8'h00, 1'b0, 8'h00);
    check("periph_unmapped", last_rd, 8'h00);

    if (FIFO_EN) begin
      do_reset();
      cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'h1C);
      cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'h32);
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("status_two", last_rd, 8'h21);
      cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("pop_first", last_rd, 8'h1C);
      cyc(IDLE, 1'b0, 8'h00, 1'b0, 8'h00);
      cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("pop_second", last_rd, 8'h32);
      cyc(IDLE, 1'b0, 8'h00, 1'b0, 8'h00);
      cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("pop_empty", last_rd, 8'h00);
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("status_empty", last_rd, 8'h00);
      cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'h44);
      cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'h55);
      repeat (3) cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00);
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("hold_pops_once", last_rd, 8'h11);
      cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("after_hold", last_rd, 8'h55);

      do_reset();
      for (int i = 0; i < 9; i++) cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'(8'h60 + i));
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("status_ovf", last_rd, 8'h83);
      cyc(ST, 1'b1, 8'h5E, 1'b0, 8'h00);
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("ovf_cleared", last_rd, 8'h81);
      for (int i = 0; i < 8; i++) begin
        cyc(IDLE, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("ovf_intact", last_rd, 32'(8'h60 + i));
      end

      do_reset();
      for (int i = 0; i < 8; i++) cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'(8'h70 + i));
      cyc(DT, 1'b0, 8'h00, 1'b1, 8'hAA); check("full_pushpop_head", last_rd, 8'h70);
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("full_pushpop_count", last_rd, 8'h81);
      for (int i = 1; i < 8; i++) begin
        cyc(IDLE, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("full_order", last_rd, 32'(8'h70 + i));
      end
      cyc(IDLE, 1'b0, 8'h00, 1'b0, 8'h00);
      cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("full_tail", last_rd, 8'hAA);
    end else begin
      do_reset();
      cyc(IDLE, 1'b0, 8'h00, 1'b1, 8'h1C);
      cyc(ST, 1'b0, 8'h00, 1'b0, 8'h00); check("nofifo_status", last_rd, 8'h00);
      cyc(DT, 1'b0, 8'h00, 1'b0, 8'h00); check("nofifo_data", last_rd, 8'h00);
    end

    do_reset();
    repeat (1000) cyc(IDLE, 1'b0, 8'h00, 1'b0, 8'h00);
    t0 = mt;
    cyc(PB + 20'd2, 1'b0, 8'h00, 1'b0, 8'h00); tv[7:0]   = last_rd;
    cyc(PB + 20'd3, 1'b0, 8'h00, 1'b0, 8'h00); tv[15:8]  = last_rd;
    cyc(PB + 20'd4, 1'b0, 8'h00, 1'b0, 8'h00); tv[23:16] = last_rd;
    cyc(PB + 20'd5, 1'b0, 8'h00, 1'b0, 8'h00); tv[31:24] = last_rd;
    check("ticks_snapshot", tv, t0);
    check("ticks_count", t0, 32'd1000);
    cyc(PB + 20'd2, 1'b0, 8'h00, 1'b0, 8'h00);
    do_reset();
    cyc(PB + 20'd3, 1'b0, 8'h00, 1'b0, 8'h00); check("ticks_reset", last_rd, 8'h00);

    ra = IDLE;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          case ($urandom_range(0, 4))
            0: ra = 20'h01234;
            1: ra = 20'h00010;
            2: ra = 20'hDFFFF;
            3: ra = 20'hE0010;
            default: ra = 20'hEFFFF;
          endcase
        end
        3: ra = ($urandom_range(0, 1) == 0) ? 20'hF0010 : 20'hF0000;
        4, 5, 6, 7: ra = PB + 20'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 5));
        default: ;
      endcase
      cyc(ra, $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/membus_target.md
# membus_target

Byte-wide bus target for the 8-bit x86 core: it answers the core's `address`/`out`/`wren` bus and drives the core's `data` input. It decodes every access into external RAM, write-protected ROM, or a small peripheral window, and returns read data with a fixed one-cycle latency. The peripheral window holds a keyboard scancode FIFO and a free-running tick counter read through a snapshot latch. It sits between the core and the system BRAM/ROM in the top level.

## Interface
- `FIFO_DEPTH`, 8: scancode FIFO entries; must be a power of 2, range 2..16.
- `PERIPH_BASE`, 20'hE0000: base of the 16-byte peripheral window; the low 4 bits must be 0.
- `clock` in 1: the single clock; all logic runs on its rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `address` in 20: core address.
- `wdata` in 8: core write data (the core's `out`).
- `wren` in 1: core write strobe.
- `rdata` out 8: read data to the core's `data`.
- `mem_addr` out 20: memory address; equals `address`, combinational.
- `mem_wdata` out 8: equals `wdata`, combinational.
- `mem_we` out 1: `wren` qualified by the decode.
- `mem_q` in 8: memory read data, valid one cycle after `mem_addr`.
- `kbd_data` in 8: scancode from the keyboard front end.
- `kbd_valid` in 1: single-cycle push strobe.

## Operation
- Decode of the current `address`:
  - RAM: 00000h–EFFFFh, excluding the peripheral window.
  - ROM: F0000h–FFFFFh.
  - PERIPH: `PERIPH_BASE`..+15.
- `mem_we` = `wren` & RAM. Writes to ROM and unmapped peripheral offsets are silently dropped.
- Read path: the region select and offset are registered in the access cycle. Next cycle:
  - `rdata` = `mem_q` for RAM or ROM.
  - `rdata` = the registered peripheral byte for PERIPH.
- Peripheral map, by offset:
  - 0 STATUS (read): bit0 = FIFO non-empty, bit1 = overflow (sticky), bits7:4 = count; all other bits 0.
  - 1 DATA (read): head of the FIFO, popped. An empty FIFO returns 00h and pops nothing.
  - 2 TICKS0 (read): the read latches the whole 32-bit counter into the snapshot and returns byte 0 of the snapshot.
  - 3..5 TICKS1..3 (read): bytes 1..3 of the snapshot; these reads do not re-latch.
  - 0 (write): any value clears overflow.
  - 6..15: read 00h.
- Access qualification: a peripheral side effect (pop, latch) fires only on the first cycle of an access. A first cycle is one where `address` differs from the previous cycle's `address`, or the previous cycle had `wren`=1. The core may hold an address for several cycles; this prevents repeated pops.
- FIFO:
  - Circular buffer with a wrapping read pointer, write pointer and count.
  - A push when full drops the byte and sets overflow.
  - A simultaneous push and pop performs both; count is unchanged. When the FIFO is full the push is accepted because the pop frees a slot.
  - A push when empty is readable on the next access.
- Tick counter: 32-bit, increments every cycle, wraps from FFFFFFFFh to 0.

## Timing
- Reset (`reset_n`=0 at an edge):
  - `rdata`=00h, FIFO empty, pointers 0, overflow 0, counter 0, snapshot 0, previous-address register 0.
  - `mem_we` is 0 during reset.
  - Reset in the middle of a multi-byte TICKS read discards the snapshot.
- Read latency is exactly 1 cycle: address at cycle N, `rdata` valid at cycle N+1.
- A pop at cycle N: count drops at N+1; the popped byte is on `rdata` at N+1.
- A push at cycle N is reflected in STATUS for an access at cycle N+1 or later.
- A TICKS0 access at cycle N latches the counter value of cycle N.

## Configuration
- `MEMBUS_KBD_FIFO_EN` defined: FIFO, overflow flag and the STATUS/DATA registers as described.
- Not defined:
  - No FIFO storage.
  - `kbd_data`/`kbd_valid` are ignored.
  - STATUS and DATA read 00h; the write to offset 0 is ignored.
  - The tick counter is unaffected.

## Structure
- Shared package `membus_pkg`:
  - region encoding (RAM/ROM/PERIPH);
  - peripheral offset constants (STATUS, DATA, TICKS0..3);
  - ROM and RAM bound constants.
- One sub-module, `scancode_fifo`: push/pop/full/empty/count/overflow. It is instantiated only under `MEMBUS_KBD_FIFO_EN`.

## Test plan
- RAM round trip: write 5Ah at 01234h; read 01234h → `rdata`=5Ah at N+1. `mem_we` is high only in the write cycle.
- ROM protection: write FFh at F0010h → `mem_we` stays 0. A read returns the preloaded `mem_q` value.
- FIFO order: push 1Ch, 32h; read STATUS → 21h; DATA → 1Ch; DATA → 32h; DATA → 00h; STATUS → 00h. Holding the DATA address for 3 cycles pops once.
- Overflow: push 9 bytes with depth 8 → STATUS = 83h. Write to offset 0 → STATUS = 81h. The first 8 bytes are intact.
- Simultaneous push and pop at full: count stays 8, the popped byte is the oldest, the new byte is at the tail.
- Ticks: preset by running 1000 cycles, then read TICKS0..3 in consecutive accesses → a consistent 32-bit value equal to the cycle count at the TICKS0 access. Reset mid-sequence → a subsequent TICKS1 read returns 00h.
